voice_allocator: RTL and testbench

//  Polyphony scheduler for the note_bank voices: accepts note-on/off events over a

---
 rtl/voice_allocator.sv | 206 ++++++++++++++++++++
 tb/tb_voice_allocator.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// Polyphony scheduler: accepts note-on/off events, allocates or steals voices, routes note-off.
// Optional VOICE_ALLOC_STATS_EN adds steal_cnt/drop_cnt counters.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int PERIOD_W   = 26,
  parameter int AGE_W      = 8
) (
  input  logic                           clk,
  input  logic                           rst_b,
  input  logic                           ev_valid,
  output logic                           ev_ready,
  input  logic                           ev_on,
  input  logic [6:0]                     ev_key,
  input  logic [PERIOD_W-1:0]            ev_period,
  input  logic [NUM_VOICES-1:0]          v_busy,
  output logic [NUM_VOICES-1:0]          v_note_on,
  output logic [NUM_VOICES-1:0]          v_note_off,
  output logic [NUM_VOICES*PERIOD_W-1:0] v_period,
  output logic [NUM_VOICES-1:0]          v_held,
`ifdef VOICE_ALLOC_STATS_EN
  output logic [15:0]                    steal_cnt,
  output logic [15:0]                    drop_cnt,
`endif
  output logic [1:0]                     dbg_state
);

  // Handshake: an event transfers on a rising edge where ev_valid && ev_ready;
  // ev_ready is high only in IDLE, and ev_* are don't-care otherwise.

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECIDE = 2'd1,
    S_STEAL  = 2'd2,
    S_ISSUE  = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic [IDX_W-1:0] tgt_q, tgt_d;
  logic init_q;

  logic                ev_on_q;
  logic [6:0]          ev_key_q;
  logic [PERIOD_W-1:0] ev_period_q;

  logic [NUM_VOICES-1:0]                held_q;
  logic [NUM_VOICES-1:0][6:0]           key_q;
  logic [NUM_VOICES-1:0][AGE_W-1:0]     age_q;
  logic [NUM_VOICES-1:0][PERIOD_W-1:0]  period_q;
  logic [NUM_VOICES-1:0]                on_q;
  logic [NUM_VOICES-1:0]                off_q;

  logic accept;
  logic steal_ev, drop_ev;

  logic             match_hit, free_hit, tail_hit;
  logic [IDX_W-1:0] match_idx, free_idx, tail_idx, old_idx;
  logic [AGE_W-1:0] old_age;

  assign ev_ready   = (state_q == S_IDLE) && init_q;
  assign accept     = ev_valid && ev_ready;
  assign v_note_on  = on_q;
  assign v_note_off = off_q;
  assign v_period   = period_q;
  assign v_held     = held_q;
  assign dbg_state  = state_q;

  // Candidate search over all voices; each class keeps its lowest index.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    tail_hit  = 1'b0;
    tail_idx  = '0;
    old_idx   = '0;
    old_age   = age_q[0];
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!match_hit && held_q[i] && (key_q[i] == ev_key_q)) begin
        match_hit = 1'b1;
        match_idx = IDX_W'(i);
      end
      if (!free_hit && !held_q[i] && !v_busy[i]) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (!tail_hit && !held_q[i]) begin
        tail_hit = 1'b1;
        tail_idx = IDX_W'(i);
      end
    end
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (age_q[i] > old_age) begin
        old_age = age_q[i];
        old_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    steal_ev = 1'b0;
    drop_ev  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_DECIDE;
      end
      S_DECIDE: begin
        if (ev_on_q) begin
          state_d = S_ISSUE;
          if (match_hit)     tgt_d = match_idx;
          else if (free_hit) tgt_d = free_idx;
          else if (tail_hit) tgt_d = tail_idx;
          else begin
            tgt_d    = old_idx;
            state_d  = S_STEAL;
            steal_ev = 1'b1;
          end
        end else if (match_hit) begin
          tgt_d   = match_idx;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
          drop_ev = 1'b1;
        end
      end
      S_STEAL: state_d = S_ISSUE;
      S_ISSUE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pulses are registered so they appear together with the held/period update.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      init_q      <= 1'b0;
      ev_on_q     <= 1'b0;
      ev_key_q    <= '0;
      ev_period_q <= '0;
      held_q      <= '0;
      key_q       <= '0;
      age_q       <= '0;
      period_q    <= '0;
      on_q        <= '0;
      off_q       <= '0;
    end else begin
      init_q <= 1'b1;
      on_q   <= '0;
      off_q  <= '0;
      if (accept) begin
        ev_on_q     <= ev_on;
        ev_key_q    <= ev_key;
        ev_period_q <= ev_period;
      end
      if (state_q == S_STEAL) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (tgt_q == IDX_W'(i)) off_q[i] <= 1'b1;
        end
      end
      if (state_q == S_ISSUE) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (tgt_q == IDX_W'(i)) begin
            if (ev_on_q) begin
              on_q[i]     <= 1'b1;
              period_q[i] <= ev_period_q;
              key_q[i]    <= ev_key_q;
              held_q[i]   <= 1'b1;
              age_q[i]    <= '0;
            end else begin
              off_q[i]  <= 1'b1;
              held_q[i] <= 1'b0;
            end
          end else if (ev_on_q && held_q[i] && (age_q[i] != AGE_MAX)) begin
            age_q[i] <= age_q[i] + 1'b1;
          end
        end
      end
    end
  end

`ifdef VOICE_ALLOC_STATS_EN
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      steal_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (steal_ev) steal_cnt <= steal_cnt + 16'd1;
      if (drop_ev)  drop_cnt  <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: reference voice model feeds an expected-pulse queue
// stamped with the cycle each pulse is due.
module tb_voice_allocator;
  localparam int NV = 4;
  localparam int PW = 26;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic ev_valid = 1'b0;
  logic ev_ready;
  logic ev_on = 1'b0;
  logic [6:0] ev_key = '0;
  logic [PW-1:0] ev_period = '0;
  logic [NV-1:0] tb_busy = '0;
  logic [NV-1:0] v_note_on, v_note_off, v_held;
  logic [NV*PW-1:0] v_period;
  logic [1:0] dbg_state;
`ifdef VOICE_ALLOC_STATS_EN
  logic [15:0] steal_cnt, drop_cnt;
`endif

  voice_allocator #(.NUM_VOICES(NV), .PERIOD_W(PW), .AGE_W(8)) dut (
    .clk(clk), .rst_b(rst_b), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_on(ev_on), .ev_key(ev_key), .ev_period(ev_period), .v_busy(tb_busy),
    .v_note_on(v_note_on), .v_note_off(v_note_off), .v_period(v_period),
    .v_held(v_held),
`ifdef VOICE_ALLOC_STATS_EN
    .steal_cnt(steal_cnt), .drop_cnt(drop_cnt),
`endif
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  logic          m_held[NV];
  logic [6:0]    m_key[NV];
  int            m_age[NV];
  logic [PW-1:0] m_per[NV];
  int            m_steals = 0;
  int            m_drops = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mk(input int c, input logic [3:0] off, input logic [3:0] on);
    logic [31:0] w;
    w = {c[23:0], off, on};
    return w;
  endfunction

  function automatic logic [NV-1:0] model_held_vec();
    logic [NV-1:0] v;
    for (int i = 0; i < NV; i++) v[i] = m_held[i];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NV; i++) begin
      m_held[i] = 1'b0;
      m_key[i]  = '0;
      m_age[i]  = 0;
      m_per[i]  = '0;
    end
    m_steals = 0;
    m_drops = 0;
    exp_q.delete();
  endtask

  // Pulse monitor: every pulse must match the head of the queue, including its cycle.
  logic [31:0] obs_w;
  always @(negedge clk) begin
    if (rst_b && ((v_note_on | v_note_off) != '0)) begin
      obs_w = {cyc[23:0], v_note_off, v_note_on};
      check_val("pulse_onehot", 64'($countones({v_note_off, v_note_on})), 64'd1);
      if (exp_q.size() == 0) check_val("pulse_unexpected", 64'(obs_w), 64'd0);
      else check_val("pulse", 64'(obs_w), 64'(exp_q.pop_front()));
    end
  end

  task automatic model_on(input logic [6:0] key, input logic [PW-1:0] per, input int a,
                          output int k);
    bit steal;
    logic [3:0] oh;
    k = -1;
    steal = 1'b0;
    for (int i = 0; i < NV; i++) if (k < 0 && m_held[i] && m_key[i] == key) k = i;
    for (int i = 0; i < NV; i++) if (k < 0 && !m_held[i] && !tb_busy[i]) k = i;
    for (int i = 0; i < NV; i++) if (k < 0 && !m_held[i]) k = i;
    if (k < 0) begin
      steal = 1'b1;
      k = 0;
      for (int i = 1; i < NV; i++) if (m_age[i] > m_age[k]) k = i;
    end
    oh = 4'(1 << k);
    if (steal) begin
      m_steals++;
      exp_q.push_back(mk(a + 2, oh, 4'b0));
      exp_q.push_back(mk(a + 3, 4'b0, oh));
    end else begin
      exp_q.push_back(mk(a + 2, 4'b0, oh));
    end
    for (int i = 0; i < NV; i++)
      if (i != k && m_held[i] && m_age[i] < 255) m_age[i]++;
    m_age[k] = 0;
    m_held[k] = 1'b1;
    m_key[k] = key;
    m_per[k] = per;
  endtask

  task automatic model_off(input logic [6:0] key, input int a, output bit dropped);
    int k = -1;
    for (int i = 0; i < NV; i++) if (k < 0 && m_held[i] && m_key[i] == key) k = i;
    dropped = (k < 0);
    if (dropped) m_drops++;
    else begin
      exp_q.push_back(mk(a + 2, 4'(1 << k), 4'b0));
      m_held[k] = 1'b0;
    end
  endtask

  task automatic send(input bit on, input logic [6:0] key, input logic [PW-1:0] per);
    int a;
    int t;
    int k;
    bit dropped;
    t = 0;
    k = -1;
    dropped = 1'b0;
    @(negedge clk);
    ev_valid = 1'b1;
    ev_on = on;
    ev_key = key;
    ev_period = per;
    while (!ev_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!ev_ready) begin
      check_val("ready_timeout", 64'(ev_ready), 64'd1);
      ev_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    a = cyc;
    ev_valid = 1'b0;
    ev_on = 1'($urandom_range(0, 1));
    ev_key = 7'($urandom);
    if (on) model_on(key, per, a, k);
    else model_off(key, a, dropped);
    @(negedge clk);
    check_val("ready_low_decide", 64'(ev_ready), 64'd0);
    if (dropped) begin
      @(negedge clk);
      check_val("drop_ready_back", 64'(ev_ready), 64'd1);
    end
    t = 0;
    while (exp_q.size() != 0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      check_val("pulse_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    check_val("held", 64'(v_held), 64'(model_held_vec()));
    if (k >= 0) check_val("period", 64'(v_period[k*PW +: PW]), 64'(per));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_b = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    check_val("rst_ready", 64'(ev_ready), 64'd0);
    check_val("rst_held", 64'(v_held), 64'd0);
    check_val("rst_period", 64'(v_period), 64'd0);
    check_val("rst_pulses", 64'({v_note_off, v_note_on}), 64'd0);
    rst_b = 1'b1;
    @(negedge clk);
    check_val("rst_ready_after", 64'(ev_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    do_reset();

    // 1) basic allocation
    send(1'b1, 7'd60, 26'd1000);
    check_val("t1_held", 64'(v_held), 64'h1);
    check_val("t1_period0", 64'(v_period[0 +: PW]), 64'd1000);

    // 2) fill all voices, then steal oldest
    send(1'b1, 7'd62, 26'd2000);
    send(1'b1, 7'd64, 26'd3000);
    send(1'b1, 7'd67, 26'd4000);
    send(1'b1, 7'd69, 26'd5000);
    check_val("t2_held", 64'(v_held), 64'hF);
    check_val("t2_period0", 64'(v_period[0 +: PW]), 64'd5000);
    send(1'b1, 7'd71, 26'd6000);
`ifdef VOICE_ALLOC_STATS_EN
    check_val("t2_steal_cnt", 64'(steal_cnt), 64'(m_steals));
`endif

    // 3) retrigger same key
    do_reset();
    send(1'b1, 7'd60, 26'd1000);
    send(1'b1, 7'd60, 26'd1234);
    check_val("t3_held", 64'(v_held), 64'h1);

    // 4) release and dropped note-off
    do_reset();
    send(1'b1, 7'd60, 26'd1000);
    send(1'b0, 7'd60, 26'd0);
    check_val("t4_held", 64'(v_held), 64'h0);
    send(1'b0, 7'd61, 26'd0);
`ifdef VOICE_ALLOC_STATS_EN
    check_val("t4_drop_cnt", 64'(drop_cnt), 64'd1);
`endif

    // 5) busy tail avoided, then all busy falls back to lowest unheld
    do_reset();
    send(1'b1, 7'd60, 26'd1000);
    send(1'b0, 7'd60, 26'd0);
    tb_busy = 4'b0001;
    send(1'b1, 7'd70, 26'd700);
    check_val("t5_held", 64'(v_held), 64'h2);
    tb_busy = 4'b1111;
    send(1'b1, 7'd72, 26'd720);
    check_val("t5_tail_held", 64'(v_held), 64'h3);
    tb_busy = 4'b0000;

    // 6) reset during DECIDE
    @(negedge clk);
    ev_valid = 1'b1;
    ev_on = 1'b1;
    ev_key = 7'd80;
    ev_period = 26'd999;
    check_val("t6_ready", 64'(ev_ready), 64'd1);
    @(posedge clk);
    #1;
    ev_valid = 1'b0;
    check_val("t6_in_decide", 64'(dbg_state), 64'd1);
    rst_b = 1'b0;
    model_clear();
    repeat (3) begin
      @(negedge clk);
      check_val("t6_no_pulse", 64'({v_note_off, v_note_on}), 64'd0);
    end
    check_val("t6_held", 64'(v_held), 64'd0);
    check_val("t6_period", 64'(v_period), 64'd0);
    rst_b = 1'b1;
    repeat (5) @(negedge clk);
    check_val("t6_held_after", 64'(v_held), 64'd0);

    // Random traffic over a narrow key range to exercise steals, retriggers and drops
    for (int n = 0; n < 40; n++) begin
      tb_busy = 4'($urandom_range(0, 15));
      send($urandom_range(0, 2) != 0, 7'($urandom_range(60, 67)), 26'($urandom));
    end
`ifdef VOICE_ALLOC_STATS_EN
    check_val("rand_steal_cnt", 64'(steal_cnt), 64'(m_steals));
    check_val("rand_drop_cnt", 64'(drop_cnt), 64'(m_drops));
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
